link_arbiter: RTL

- Shares one 4-phase req/ack byte link to a single slave among NUM_REQ master FSMs.
- Grants with round-robin priority and latches the winner's data.
- Forwards req to the slave and routes ack back to the winner.
- Holds the grant for the full 4-phase cycle, then rotates priority.
- Sits between the per-channel master FSMs and the shared slave port. Counts completed transfers for status.

---
 rtl/link_arbiter_if.sv | 27 ++
 rtl/link_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/link_arbiter_if.sv
// link_arbiter_if: master-side and shared-slave-side signals of the link arbiter.
// Master modport is the environment view; slave modport is the arbiter view.
interface link_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0]        m_req;
    logic [NUM_REQ*DATA_W-1:0] m_data;
    logic [NUM_REQ-1:0]        m_ack;
    logic                      s_req;
    logic [DATA_W-1:0]         s_data;
    logic                      s_ack;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic [CNT_W-1:0]          xfer_cnt;

    modport master (
        output m_req, m_data, s_ack,
        input  m_ack, s_req, s_data, grant, busy, xfer_cnt
    );

    modport slave (
        input  m_req, m_data, s_ack,
        output m_ack, s_req, s_data, grant, busy, xfer_cnt
    );
endinterface

// File: rtl/link_arbiter.sv
// link_arbiter: round-robin sharing of one 4-phase req/ack byte link
// among NUM_REQ masters, with a completed-transfer counter.
module link_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    link_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        ACK_HI,
        REQ_LO
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               s_req_q;
    logic [DATA_W-1:0]  s_data_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   win_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_data;
    logic [NUM_REQ-1:0] win_oh;
    int                 idx;

    // Round-robin search from last+1; descending loop lets the nearest hit win.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (bus.m_req[idx]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    // Winner's data word and one-hot grant vector.
    always_comb begin
        win_data = bus.m_data[int'(win_idx)*DATA_W +: DATA_W];
        win_oh   = NUM_REQ'(1) << win_idx;
    end

    // Four-phase handshake sequencer; grant held until the slave drops ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            s_req_q  <= 1'b0;
            s_data_q <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            win_q    <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q  <= REQ_HI;
                        grant_q  <= win_oh;
                        s_data_q <= win_data;
                        s_req_q  <= 1'b1;
                        win_q    <= win_idx;
                    end
                end
                REQ_HI: begin
                    if (bus.s_ack) begin
                        state_q <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (!bus.m_req[win_q]) begin
                        state_q <= REQ_LO;
                        s_req_q <= 1'b0;
                    end
                end
                REQ_LO: begin
                    if (!bus.s_ack) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        last_q  <= win_q;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ack is routed only to the owner; grant is zero whenever idle.
    assign bus.m_ack    = {NUM_REQ{bus.s_ack}} & grant_q;
    assign bus.s_req    = s_req_q;
    assign bus.s_data   = s_data_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.xfer_cnt = cnt_q;

endmodule
